// File: rtl/ntt_butterfly_sequencer.sv
// Issue sequencer for the PE0 butterfly: walks all 896 butterflies of a Kyber
// NTT/INTT pass and emits read, PE-valid and latency-matched writeback streams.
module ntt_butterfly_sequencer #(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned PE_LAT    = 4,
    parameter logic [3:0]  CTRL_NTT  = 4'b0000,
    parameter logic [3:0]  CTRL_INTT = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       mode_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [6:0] zeta_idx_o,
    output logic       pe_valid_o,
    output logic [3:0] pe_ctrl_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam int unsigned L        = MEM_LAT + PE_LAT;
    localparam logic [7:0]  GAP_LAST = 8'(L - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     state_r, state_nxt_s;
    logic       mode_r, mode_nxt_s;
    logic [6:0] idx_r, idx_nxt_s;
    logic [2:0] layer_r, layer_nxt_s;
    logic [6:0] k_r, k_nxt_s;
    logic [7:0] gap_r, gap_nxt_s;

    logic [7:0] len_s, mask_s, len_nxt_s;
    logic       last_in_group_s, last_of_pass_s;

    logic       rd_en_nxt_s, busy_nxt_s, done_nxt_s;
    logic [7:0] rd_a_nxt_s, rd_b_nxt_s;
    logic [6:0] k_out_nxt_s;
    logic [3:0] ctrl_cur_s;

    logic       busy_r, done_r, rd_en_r;
    logic [7:0] rd_a_r, rd_b_r;
    logic [6:0] zeta_r;

    logic [L-1:0] en_pipe_r;
    logic [7:0]   a_pipe_r    [L];
    logic [7:0]   b_pipe_r    [L];
    logic [3:0]   ctrl_pipe_r [MEM_LAT];

    // Butterfly span of a layer: NTT halves from 128, INTT doubles from 2.
    function automatic logic [7:0] len_of(input logic [2:0] layer, input logic mode);
        len_of = mode ? (8'd2 << layer) : (8'd128 >> layer);
    endfunction

    // Index a of issue idx: a zero bit is inserted at position log2(len).
    function automatic logic [7:0] addr_of(input logic [6:0] idx, input logic [7:0] len);
        logic [7:0] ix;
        logic [7:0] mask;
        ix      = {1'b0, idx};
        mask    = len - 8'd1;
        addr_of = ((ix & ~mask) << 3'd1) | (ix & mask);
    endfunction

    assign len_s           = len_of(layer_r, mode_r);
    assign mask_s          = len_s - 8'd1;
    assign last_in_group_s = (({1'b0, idx_r} & mask_s) == mask_s);
    assign last_of_pass_s  = (layer_r == 3'd6) && (idx_r == 7'd127);

    // FSM state register together with its layer/issue/twiddle/gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            idx_r   <= 7'd0;
            layer_r <= 3'd0;
            k_r     <= 7'd0;
            gap_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            idx_r   <= idx_nxt_s;
            layer_r <= layer_nxt_s;
            k_r     <= k_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        idx_nxt_s   = idx_r;
        layer_nxt_s = layer_r;
        k_nxt_s     = k_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_RUN;
                    mode_nxt_s  = mode_i;
                    idx_nxt_s   = 7'd0;
                    layer_nxt_s = 3'd0;
                    k_nxt_s     = mode_i ? 7'd127 : 7'd1;
                    gap_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == 7'd127) begin
                    idx_nxt_s = 7'd0;
                    gap_nxt_s = 8'd0;
                    if (layer_r == 3'd6) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_GAP;
                        layer_nxt_s = layer_r + 3'd1;
                    end
                end else begin
                    idx_nxt_s = idx_r + 7'd1;
                end
                // k stops on the final group so it never steps past 127 or 1.
                if (last_in_group_s && !last_of_pass_s) begin
                    k_nxt_s = mode_r ? (k_r - 7'd1) : (k_r + 7'd1);
                end else begin
                    k_nxt_s = k_r;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt_s = ST_RUN;
                    gap_nxt_s   = 8'd0;
                end else begin
                    gap_nxt_s = gap_r + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt_s = ST_DONE;
                    gap_nxt_s   = 8'd0;
                end else begin
                    gap_nxt_s = gap_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                mode_nxt_s  = 1'b0;
                idx_nxt_s   = 7'd0;
                layer_nxt_s = 3'd0;
                k_nxt_s     = 7'd0;
                gap_nxt_s   = 8'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                mode_nxt_s  = 1'b0;
                idx_nxt_s   = 7'd0;
                layer_nxt_s = 3'd0;
                k_nxt_s     = 7'd0;
                gap_nxt_s   = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the issue port is registered.
    always_comb begin
        len_nxt_s   = len_of(layer_nxt_s, mode_nxt_s);
        rd_en_nxt_s = (state_nxt_s == ST_RUN);
        busy_nxt_s  = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_GAP) ||
                      (state_nxt_s == ST_DRAIN);
        done_nxt_s  = (state_nxt_s == ST_DONE);
        if (rd_en_nxt_s) begin
            rd_a_nxt_s  = addr_of(idx_nxt_s, len_nxt_s);
            rd_b_nxt_s  = addr_of(idx_nxt_s, len_nxt_s) | len_nxt_s;
            k_out_nxt_s = k_nxt_s;
        end else begin
            rd_a_nxt_s  = 8'd0;
            rd_b_nxt_s  = 8'd0;
            k_out_nxt_s = 7'd0;
        end
    end

    // Registered issue-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
            rd_a_r  <= 8'd0;
            rd_b_r  <= 8'd0;
            zeta_r  <= 7'd0;
        end else begin
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            rd_en_r <= rd_en_nxt_s;
            rd_a_r  <= rd_a_nxt_s;
            rd_b_r  <= rd_b_nxt_s;
            zeta_r  <= k_out_nxt_s;
        end
    end

    assign ctrl_cur_s = rd_en_r ? (mode_r ? CTRL_INTT : CTRL_NTT) : 4'b0000;

    // Free-running delay lines; PE valid taps the shared enable line at MEM_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_pipe_r <= '0;
            for (int i = 0; i < int'(L); i++) begin
                a_pipe_r[i] <= 8'd0;
                b_pipe_r[i] <= 8'd0;
            end
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                ctrl_pipe_r[i] <= 4'b0000;
            end
        end else begin
            en_pipe_r[0] <= rd_en_r;
            a_pipe_r[0]  <= rd_a_r;
            b_pipe_r[0]  <= rd_b_r;
            for (int i = 1; i < int'(L); i++) begin
                en_pipe_r[i] <= en_pipe_r[i-1];
                a_pipe_r[i]  <= a_pipe_r[i-1];
                b_pipe_r[i]  <= b_pipe_r[i-1];
            end
            ctrl_pipe_r[0] <= ctrl_cur_s;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                ctrl_pipe_r[i] <= ctrl_pipe_r[i-1];
            end
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign rd_en_o     = rd_en_r;
    assign rd_addr_a_o = rd_a_r;
    assign rd_addr_b_o = rd_b_r;
    assign zeta_idx_o  = zeta_r;
    assign pe_valid_o  = en_pipe_r[MEM_LAT-1];
    assign pe_ctrl_o   = ctrl_pipe_r[MEM_LAT-1];
    assign wr_en_o     = en_pipe_r[L-1];
    assign wr_addr_a_o = a_pipe_r[L-1];
    assign wr_addr_b_o = b_pipe_r[L-1];

endmodule

// File: tb/tb_ntt_butterfly_sequencer.sv
// Randomised-order bench: two sequencers (MEM_LAT=1 and 2) checked each cycle
// against an arithmetic model of the butterfly schedule.
module tb_ntt_butterfly_sequencer;

    logic clk = 1'b0;
    logic rst, start_i, mode_i;

    logic       busy0, done0, rd_en0, pv0, we0;
    logic [7:0] ra0, rb0, wa0, wb0;
    logic [6:0] zk0;
    logic [3:0] pc0;
    logic       busy1, done1, rd_en1, pv1, we1;
    logic [7:0] ra1, rb1, wa1, wb1;
    logic [6:0] zk1;
    logic [3:0] pc1;

    int checks = 0;
    int errors = 0;
    int wr_cnt [2];
    int done_cnt [2];
    int done_cyc [2];

    always #5 clk = ~clk;

    ntt_butterfly_sequencer dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy0), .done_o(done0), .rd_en_o(rd_en0),
        .rd_addr_a_o(ra0), .rd_addr_b_o(rb0), .zeta_idx_o(zk0),
        .pe_valid_o(pv0), .pe_ctrl_o(pc0), .wr_en_o(we0),
        .wr_addr_a_o(wa0), .wr_addr_b_o(wb0)
    );

    ntt_butterfly_sequencer #(.MEM_LAT(2), .PE_LAT(4)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy1), .done_o(done1), .rd_en_o(rd_en1),
        .rd_addr_a_o(ra1), .rd_addr_b_o(rb1), .zeta_idx_o(zk1),
        .pe_valid_o(pv1), .pe_ctrl_o(pc1), .wr_en_o(we1),
        .wr_addr_a_o(wa1), .wr_addr_b_o(wb1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Which butterfly (if any) is issued in cycle c of a pass started in cycle 0.
    function automatic void model_issue(input int c, input int lat, input bit m,
                                        output bit en, output int a, output int b, output int k);
        int t, per, layer, off, len, g, gb;
        en = 1'b0; a = 0; b = 0; k = 0;
        if (c < 1) return;
        t = c - 1;
        per = 128 + lat;
        layer = t / per;
        off = t % per;
        if (layer > 6 || off >= 128) return;
        gb = 0;
        for (int n = 0; n < layer; n++) gb += 128 / (m ? (2 << n) : (128 >> n));
        len = m ? (2 << layer) : (128 >> layer);
        g = off / len;
        a = g * 2 * len + off % len;
        b = a + len;
        k = m ? 127 - gb - g : 1 + gb + g;
        en = 1'b1;
    endfunction

    task automatic check_dut(input int id, input int c, input bit m, input int ml, input int lat,
                             input int rst_cyc, input int busy, input int done, input int rd_en,
                             input int ra, input int rb, input int zk, input int pv, input int pc,
                             input int we, input int wa, input int wb);
        bit killed, en, pven, wen;
        int a, b, k, wa_e, wb_e, xa, xb, xk;
        string p;
        p = $sformatf("d%0d c%0d", id, c);
        killed = (rst_cyc >= 0) && (c > rst_cyc);
        model_issue(c, lat, m, en, a, b, k);
        model_issue(c - ml, lat, m, pven, xa, xb, xk);
        model_issue(c - lat, lat, m, wen, wa_e, wb_e, xk);
        if (killed) begin
            en = 1'b0; a = 0; b = 0; k = 0;
            pven = 1'b0; wen = 1'b0; wa_e = 0; wb_e = 0;
        end
        chk({p, " rd_en"}, rd_en, int'(en));
        chk({p, " rd_a"}, ra, a);
        chk({p, " rd_b"}, rb, b);
        chk({p, " zeta"}, zk, k);
        chk({p, " pe_valid"}, pv, int'(pven));
        chk({p, " pe_ctrl"}, pc, (pven && m) ? 1 : 0);
        chk({p, " wr_en"}, we, int'(wen));
        chk({p, " wr_a"}, wa, wa_e);
        chk({p, " wr_b"}, wb, wb_e);
        chk({p, " done"}, done, int'(!killed && c == 897 + 7 * lat));
        chk({p, " busy"}, busy, int'(!killed && c >= 1 && c <= 896 + 7 * lat));
        if (we != 0) wr_cnt[id]++;
        if (done != 0) begin
            done_cnt[id]++;
            done_cyc[id] = c;
        end
    endtask

    // One pass: start in cycle 0, optional stray start at cycle mid, optional reset at rst_cyc.
    task automatic run_pass(input bit m, input int mid, input int rst_cyc, input int maxc);
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
        end
        for (int c = 0; c <= maxc; c++) begin
            @(negedge clk);
            check_dut(0, c, m, 1, 5, rst_cyc, busy0, done0, rd_en0, ra0, rb0, zk0,
                      pv0, pc0, we0, wa0, wb0);
            check_dut(1, c, m, 2, 6, rst_cyc, busy1, done1, rd_en1, ra1, rb1, zk1,
                      pv1, pc1, we1, wa1, wb1);
            start_i = (c == 0) || (c == mid);
            mode_i  = (c == mid) ? ~m : m;
            rst     = (c == rst_cyc);
        end
        start_i = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic check_full_pass(input string nm);
        chk({nm, " wr count d0"}, wr_cnt[0], 896);
        chk({nm, " wr count d1"}, wr_cnt[1], 896);
        chk({nm, " done count d0"}, done_cnt[0], 1);
        chk({nm, " done count d1"}, done_cnt[1], 1);
        chk({nm, " done cycle d0"}, done_cyc[0], 932);
        chk({nm, " done cycle d1"}, done_cyc[1], 939);
    endtask

    task automatic pin(input string nm, input int c, input bit m, input int ea, input int eb, input int ek);
        bit en;
        int a, b, k;
        model_issue(c, 5, m, en, a, b, k);
        chk({nm, " en"}, int'(en), 1);
        chk({nm, " a"}, a, ea);
        chk({nm, " b"}, b, eb);
        chk({nm, " k"}, k, ek);
    endtask

    initial begin
        bit en;
        int a, b, k, gap_seed;
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0;
        repeat (3) @(negedge clk);
        check_dut(0, 0, 1'b0, 1, 5, -1, busy0, done0, rd_en0, ra0, rb0, zk0, pv0, pc0, we0, wa0, wb0);
        check_dut(1, 0, 1'b0, 2, 6, -1, busy1, done1, rd_en1, ra1, rb1, zk1, pv1, pc1, we1, wa1, wb1);
        rst = 1'b0;

        pin("m c1",   1,   1'b0, 0,   128, 1);
        pin("m c128", 128, 1'b0, 127, 255, 1);
        pin("m c134", 134, 1'b0, 0,   64,  2);
        pin("m c198", 198, 1'b0, 128, 192, 3);
        pin("m c799", 799, 1'b0, 0,   2,   64);
        pin("m c800", 800, 1'b0, 1,   3,   64);
        pin("m c801", 801, 1'b0, 4,   6,   65);
        pin("m c926", 926, 1'b0, 253, 255, 127);
        pin("m i1",   1,   1'b1, 0,   2,   127);
        pin("m i2",   2,   1'b1, 1,   3,   127);
        pin("m i3",   3,   1'b1, 4,   6,   126);
        pin("m i799", 799, 1'b1, 0,   128, 1);
        gap_seed = 129 + int'($urandom_range(4, 0));
        model_issue(gap_seed, 5, 1'b0, en, a, b, k);
        chk("m gap en", int'(en), 0);

        repeat (int'($urandom_range(4, 1))) @(negedge clk);
        run_pass(1'b0, 300, -1, 945);
        check_full_pass("ntt");
        repeat (int'($urandom_range(4, 1))) @(negedge clk);
        run_pass(1'b1, -1, -1, 945);
        check_full_pass("intt");
        run_pass(1'b0, -1, 400, 460);
        chk("rst done d0", done_cnt[0], 0);
        chk("rst done d1", done_cnt[1], 0);
        run_pass(1'b0, -1, -1, 945);
        check_full_pass("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
